gray_pos_tracker: RTL and testbench

- Receiving end of the team's binary-to-Gray encoder path.
- Samples an asynchronous W-bit Gray-coded bus (rotary/absolute encoder or clock-domain-crossing pointer) through a 2-flop synchronizer and decodes it to binary.
- Detects single-step up/down motion or illegal multi-step jumps, and maintains a signed position accumulator plus a saturating error counter.
- Sits between the off-chip or cross-domain Gray source and the control logic that consumes position and direction.

---
 rtl/gray_pos_tracker_pkg.sv | 34 +++
 rtl/gray_pos_tracker_if.sv | 32 +++
 rtl/gray_pos_tracker_gray2bin.sv | 16 +
 rtl/gray_pos_tracker.sv | 125 ++++++++++++
 tb/tb_gray_pos_tracker.sv | 210 +++++++++++++++++++++
 5 files changed

// File: rtl/gray_pos_tracker_pkg.sv
// Shared constants, event encoding and Gray helpers for Gray-code consumers.
//   W_DEF  : default Gray/binary width
//   PW_DEF : default position accumulator width
//   EW_DEF : default error counter width
package gray_pos_tracker_pkg;

  localparam int unsigned W_DEF  = 4;
  localparam int unsigned PW_DEF = 16;
  localparam int unsigned EW_DEF = 8;

  // Classification of one decoded-sample delta
  typedef enum logic [1:0] {
    EV_NONE = 2'd0,
    EV_UP   = 2'd1,
    EV_DN   = 2'd2,
    EV_ERR  = 2'd3
  } ev_e;

  // Gray to binary at the default width: b[i] = XOR of g[W-1:i]
  function automatic logic [W_DEF-1:0] g2b(input logic [W_DEF-1:0] g);
    logic [W_DEF-1:0] b;
    b[W_DEF-1] = g[W_DEF-1];
    for (int i = int'(W_DEF) - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  // Binary to Gray at the default width (matching encoder)
  function automatic logic [W_DEF-1:0] b2g(input logic [W_DEF-1:0] b);
    return b ^ (b >> 1);
  endfunction

endpackage

// File: rtl/gray_pos_tracker_if.sv
// Bus between a Gray source/consumer and the position tracker.
//   master : drives gray_in/clear, observes decoded results
//   slave  : the tracker; samples gray_in/clear, drives results
interface gray_pos_tracker_if
  import gray_pos_tracker_pkg::*;
#(
  parameter int unsigned W  = W_DEF,
  parameter int unsigned PW = PW_DEF,
  parameter int unsigned EW = EW_DEF
);

  logic [W-1:0]  gray_in;
  logic          clear;
  logic [W-1:0]  bin_out;
  logic          valid;
  logic          step_up;
  logic          step_dn;
  logic          err;
  logic [PW-1:0] pos;
  logic [EW-1:0] err_cnt;

  modport master (
    output gray_in, clear,
    input  bin_out, valid, step_up, step_dn, err, pos, err_cnt
  );

  modport slave (
    input  gray_in, clear,
    output bin_out, valid, step_up, step_dn, err, pos, err_cnt
  );

endinterface

// File: rtl/gray_pos_tracker_gray2bin.sv
// Combinational W-bit Gray to binary decoder (inverse of the team encoder).
//   gray_i : Gray-coded input
//   bin_o  : binary result (combinational)
module gray_pos_tracker_gray2bin #(
  parameter int unsigned W = 4
) (
  input  logic [W-1:0] gray_i,
  output logic [W-1:0] bin_o
);

  // Each binary bit is the XOR of all Gray bits at or above it
  for (genvar i = 0; i < int'(W); i++) begin : g_bit
    assign bin_o[i] = ^gray_i[W-1:i];
  end

endmodule

// File: rtl/gray_pos_tracker.sv
// Synchronizes an asynchronous Gray bus, decodes it, and tracks motion.
//   clk, rst_n : clock and async active-low reset
//   bus        : slave side; gray_in/clear in, bin_out/valid/step_up/
//                step_dn/err/pos/err_cnt out (all registered)
module gray_pos_tracker
  import gray_pos_tracker_pkg::*;
#(
  parameter int unsigned W  = W_DEF,
  parameter int unsigned PW = PW_DEF,
  parameter int unsigned EW = EW_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  gray_pos_tracker_if.slave   bus
);

  localparam int unsigned FW = 2;

  logic [W-1:0]  s1_q, s1_d;
  logic [W-1:0]  s2_q, s2_d;
  logic [W-1:0]  bin_q, bin_d;
  logic [FW-1:0] fill_q, fill_d;
  logic          valid_q, valid_d;
  logic          up_q, up_d;
  logic          dn_q, dn_d;
  logic          err_q, err_d;
  logic [PW-1:0] pos_q, pos_d;
  logic [EW-1:0] ecnt_q, ecnt_d;

  logic [W-1:0]  dec_c;
  logic [W-1:0]  delta_c;
  ev_e           ev_c;

  // Decoder sits on s2 only; s1 may be metastable
  gray_pos_tracker_gray2bin #(.W(W)) u_g2b (
    .gray_i (s2_q),
    .bin_o  (dec_c)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q    <= '0;
      s2_q    <= '0;
      bin_q   <= '0;
      fill_q  <= '0;
      valid_q <= 1'b0;
      up_q    <= 1'b0;
      dn_q    <= 1'b0;
      err_q   <= 1'b0;
      pos_q   <= '0;
      ecnt_q  <= '0;
    end else begin
      s1_q    <= s1_d;
      s2_q    <= s2_d;
      bin_q   <= bin_d;
      fill_q  <= fill_d;
      valid_q <= valid_d;
      up_q    <= up_d;
      dn_q    <= dn_d;
      err_q   <= err_d;
      pos_q   <= pos_d;
      ecnt_q  <= ecnt_d;
    end
  end

  // Next state: pipeline advance, delta classification, accumulators
  always_comb begin
    s1_d    = bus.gray_in;
    s2_d    = s1_q;
    bin_d   = dec_c;
    fill_d  = (fill_q == FW'(3)) ? FW'(3) : fill_q + FW'(1);
    valid_d = (fill_d == FW'(3));
    up_d    = 1'b0;
    dn_d    = 1'b0;
    err_d   = 1'b0;
    pos_d   = pos_q;
    ecnt_d  = ecnt_q;
    delta_c = dec_c - bin_q;
    ev_c    = EV_NONE;

    // Compare only once bin_q holds a real sample, so reset values never
    // produce an event
    if (fill_q == FW'(3)) begin
      if (delta_c == '0)            ev_c = EV_NONE;
      else if (delta_c == W'(1))    ev_c = EV_UP;
      else if (delta_c == {W{1'b1}}) ev_c = EV_DN;
      else                          ev_c = EV_ERR;
    end

    case (ev_c)
      EV_UP: begin
        up_d  = 1'b1;
        pos_d = pos_q + PW'(1);
      end
      EV_DN: begin
        dn_d  = 1'b1;
        pos_d = pos_q - PW'(1);
      end
      EV_ERR: begin
        err_d = 1'b1;
        if (ecnt_q != {EW{1'b1}}) ecnt_d = ecnt_q + EW'(1);
      end
      default: ;
    endcase

    // Clear wins over any coincident event
    if (bus.clear) begin
      up_d   = 1'b0;
      dn_d   = 1'b0;
      err_d  = 1'b0;
      pos_d  = '0;
      ecnt_d = '0;
    end
  end

  assign bus.bin_out = bin_q;
  assign bus.valid   = valid_q;
  assign bus.step_up = up_q;
  assign bus.step_dn = dn_q;
  assign bus.err     = err_q;
  assign bus.pos     = pos_q;
  assign bus.err_cnt = ecnt_q;

endmodule

// File: tb/tb_gray_pos_tracker.sv
// Directed self-checking bench for gray_pos_tracker (W=4, PW=16, EW=8).
module tb_gray_pos_tracker;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;
  int   seq [32];
  int   ups;
  int   dns;

  gray_pos_tracker_if #(.W(4), .PW(16), .EW(8)) bus ();

  gray_pos_tracker #(.W(4), .PW(16), .EW(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance n rising edges, then settle 1ns past the edge
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reset with gray_in held at g, then release and prime for 3 edges
  task automatic do_reset(input logic [3:0] g);
    rst_n       = 1'b0;
    bus.gray_in = g;
    bus.clear   = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick(3);
  endtask

  function automatic logic [3:0] enc(input int n);
    logic [3:0] b;
    b = 4'(n);
    return b ^ (b >> 1);
  endfunction

  initial begin
    logic [3:0] gtab [4];
    logic [3:0] eb;
    logic [3:0] pb;
    logic       eu;
    logic       ed;
    total = 0;
    bad   = 0;

    // Reset state
    rst_n       = 1'b0;
    bus.gray_in = 4'b0000;
    bus.clear   = 1'b0;
    tick(2);
    chk("rst_bin",   64'(bus.bin_out), 64'd0);
    chk("rst_valid", 64'(bus.valid),   64'd0);
    chk("rst_pos",   64'(bus.pos),     64'd0);
    chk("rst_ecnt",  64'(bus.err_cnt), 64'd0);
    chk("rst_pulse", 64'({bus.step_up, bus.step_dn, bus.err}), 64'd0);

    // Priming with gray 0110 (bin 4)
    bus.gray_in = 4'b0110;
    rst_n = 1'b1;
    tick(1);
    chk("prime_v1", 64'(bus.valid), 64'd0);
    tick(1);
    chk("prime_v2", 64'(bus.valid), 64'd0);
    tick(1);
    chk("prime_v3",   64'(bus.valid),   64'd1);
    chk("prime_bin",  64'(bus.bin_out), 64'd4);
    chk("prime_puls", 64'({bus.step_up, bus.step_dn, bus.err}), 64'd0);
    tick(3);
    chk("prime_puls2", 64'({bus.step_up, bus.step_dn, bus.err}), 64'd0);
    chk("prime_pos",   64'(bus.pos), 64'd0);

    // Count up 0000 -> 0001 -> 0011 -> 0010 -> 0110
    do_reset(4'b0000);
    gtab[0] = 4'b0001; gtab[1] = 4'b0011; gtab[2] = 4'b0010; gtab[3] = 4'b0110;
    for (int i = 0; i < 4; i++) begin
      bus.gray_in = gtab[i];
      tick(2);
      chk("up_early", 64'(bus.step_up), 64'd0);
      tick(1);
      chk("up_pulse", 64'(bus.step_up), 64'd1);
      chk("up_pos",   64'(bus.pos),     64'(i + 1));
      tick(1);
      chk("up_deass", 64'(bus.step_up), 64'd0);
    end
    chk("up_bin",  64'(bus.bin_out), 64'd4);
    chk("up_ecnt", 64'(bus.err_cnt), 64'd0);

    // Wrap down 0 -> 15, then wrap up 15 -> 0
    do_reset(4'b0000);
    bus.gray_in = 4'b1000;
    tick(3);
    chk("wrap_dn",     64'(bus.step_dn), 64'd1);
    chk("wrap_dn_pos", 64'(bus.pos),     64'hFFFF);
    chk("wrap_dn_bin", 64'(bus.bin_out), 64'd15);
    bus.gray_in = 4'b0000;
    tick(3);
    chk("wrap_up",     64'(bus.step_up), 64'd1);
    chk("wrap_up_pos", 64'(bus.pos),     64'd0);
    chk("wrap_up_bin", 64'(bus.bin_out), 64'd0);

    // Illegal jump 0 -> 2, then legal 2 -> 3
    bus.gray_in = 4'b0011;
    tick(3);
    chk("jump_err",  64'(bus.err),     64'd1);
    chk("jump_ecnt", 64'(bus.err_cnt), 64'd1);
    chk("jump_pos",  64'(bus.pos),     64'd0);
    chk("jump_bin",  64'(bus.bin_out), 64'd2);
    chk("jump_up",   64'(bus.step_up), 64'd0);
    bus.gray_in = 4'b0010;
    tick(3);
    chk("resync_up",  64'(bus.step_up), 64'd1);
    chk("resync_err", 64'(bus.err),     64'd0);
    chk("resync_pos", 64'(bus.pos),     64'd1);

    // 300 illegal jumps saturate the error counter
    for (int i = 0; i < 300; i++) begin
      bus.gray_in = (i % 2 == 0) ? 4'b0000 : 4'b0011;
      tick(1);
    end
    tick(3);
    chk("sat_ecnt", 64'(bus.err_cnt), 64'd255);
    chk("sat_bin",  64'(bus.bin_out), 64'd2);
    chk("sat_pos",  64'(bus.pos),     64'd1);

    // Clear coincident with a step_up event
    bus.gray_in = 4'b0010;
    tick(2);
    chk("clr_pre_pos", 64'(bus.pos), 64'd1);
    bus.clear = 1'b1;
    tick(1);
    bus.clear = 1'b0;
    chk("clr_pulse", 64'({bus.step_up, bus.step_dn, bus.err}), 64'd0);
    chk("clr_pos",   64'(bus.pos),     64'd0);
    chk("clr_ecnt",  64'(bus.err_cnt), 64'd0);
    chk("clr_bin",   64'(bus.bin_out), 64'd3);
    chk("clr_valid", 64'(bus.valid),   64'd1);
    tick(1);
    chk("clr_after", 64'({bus.step_up, bus.pos}), 64'd0);

    // Encoder round trip 0..15..0, one value per cycle
    for (int k = 0; k < 15; k++) seq[k] = k + 1;
    seq[15] = 0;
    for (int k = 16; k < 32; k++) seq[k] = 31 - k;
    ups = 0;
    dns = 0;
    do_reset(4'b0000);
    for (int j = 0; j < 34; j++) begin
      bus.gray_in = enc((j < 32) ? seq[j] : seq[31]);
      tick(1);
      eb = (j >= 2) ? 4'(seq[j-2]) : 4'd0;
      pb = (j >= 3) ? 4'(seq[j-3]) : 4'd0;
      eu = (j >= 2) && (4'(eb - pb) == 4'd1);
      ed = (j >= 2) && (4'(eb - pb) == 4'd15);
      chk("rt_bin", 64'(bus.bin_out), 64'(eb));
      chk("rt_up",  64'(bus.step_up), 64'(eu));
      chk("rt_dn",  64'(bus.step_dn), 64'(ed));
      if (bus.step_up) ups++;
      if (bus.step_dn) dns++;
    end
    chk("rt_ups",  64'(ups), 64'd16);
    chk("rt_dns",  64'(dns), 64'd16);
    chk("rt_pos",  64'(bus.pos), 64'd0);
    chk("rt_ecnt", 64'(bus.err_cnt), 64'd0);

    // Reset asserted mid-operation
    bus.gray_in = 4'b0001;
    tick(3);
    chk("mid_up",  64'(bus.step_up), 64'd1);
    chk("mid_pos", 64'(bus.pos),     64'd1);
    rst_n = 1'b0;
    #2;
    chk("mid_rst_out", 64'({bus.bin_out, bus.valid, bus.step_up, bus.step_dn, bus.err}), 64'd0);
    chk("mid_rst_pos", 64'(bus.pos),     64'd0);
    chk("mid_rst_ec",  64'(bus.err_cnt), 64'd0);
    tick(1);
    rst_n = 1'b1;
    tick(1);
    chk("rep_v1", 64'(bus.valid), 64'd0);
    tick(1);
    chk("rep_v2", 64'(bus.valid), 64'd0);
    tick(1);
    chk("rep_v3",  64'(bus.valid),   64'd1);
    chk("rep_bin", 64'(bus.bin_out), 64'd1);
    chk("rep_ev",  64'({bus.step_up, bus.step_dn, bus.err}), 64'd0);
    tick(1);
    chk("rep_ev2", 64'({bus.step_up, bus.step_dn, bus.err}), 64'd0);
    chk("rep_pos", 64'(bus.pos), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
